// File: rtl/ising_pkg.sv
// ising_pkg: shared state encoding, width helpers and j_data layout for the Ising energy engine
package ising_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_FINISH} state_t;

    function automatic int dot_width(input int n, input int w);
        return $clog2(n) + w + 1;
    endfunction

    function automatic int energy_width(input int n, input int w);
        return w + 2 * $clog2(n) + 1;
    endfunction

    function automatic int j_offset(input int n, input int w, input int k, input int r);
        return (k * n + r) * w;
    endfunction

endpackage

// File: rtl/signed_dot_tree.sv
// signed_dot_tree: one column dot product, sum over rows of (sigma_r ? J[r] : -J[r]) via a balanced adder tree
module signed_dot_tree
    import ising_pkg::*;
#(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int J_SIGNED        = 0
) (
    input  logic [VECTOR_SIZE-1:0]                                     sigma,
    input  logic [VECTOR_SIZE*J_ELEMENT_WIDTH-1:0]                     j_col,
    output logic signed [dot_width(VECTOR_SIZE, J_ELEMENT_WIDTH)-1:0] dot
);
    localparam int N  = VECTOR_SIZE;
    localparam int W  = J_ELEMENT_WIDTH;
    localparam int DW = dot_width(N, W);

    // heap layout: leaves at N-1..2N-2, node i sums children 2i+1 and 2i+2
    logic signed [DW-1:0] node [2*N-1];

    genvar i;
    for (i = 0; i < N; i++) begin : g_leaf
        logic [W-1:0]         e;
        logic signed [DW-1:0] x;
        assign e                = j_col[i*W +: W];
        assign x                = {{(DW-W){J_SIGNED != 0 && e[W-1]}}, e};
        assign node[N-1+i]      = sigma[i] ? x : -x;
    end
    for (i = 0; i < N-1; i++) begin : g_add
        assign node[i] = node[2*i+1] + node[2*i+2];
    end

    assign dot = node[0];

endmodule

// File: rtl/ising_energy_stream.sv
// ising_energy_stream: streams J column chunks and accumulates E = sigma^T * J * sigma with a result handshake
module ising_energy_stream
    import ising_pkg::*;
#(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int COLS_PER_BEAT   = 4,
    parameter int J_SIGNED        = 0,
    parameter int PIPE_TREE       = 1
) (
    input  logic                                                       clk,
    input  logic                                                       rst_n,
    input  logic                                                       start,
    input  logic [VECTOR_SIZE-1:0]                                     sigma,
    input  logic [energy_width(VECTOR_SIZE, J_ELEMENT_WIDTH)-1:0]      energy_prev,
    input  logic                                                       j_valid,
    output logic                                                       j_ready,
    input  logic [COLS_PER_BEAT*VECTOR_SIZE*J_ELEMENT_WIDTH-1:0]       j_data,
    input  logic                                                       abort,
    output logic                                                       busy,
    output logic                                                       done,
    output logic [energy_width(VECTOR_SIZE, J_ELEMENT_WIDTH)-1:0]      energy,
    output logic                                                       improved
);
    localparam int N   = VECTOR_SIZE;
    localparam int W   = J_ELEMENT_WIDTH;
    localparam int CPB = COLS_PER_BEAT;
    localparam int NB  = N / CPB;
    localparam int DW  = dot_width(N, W);
    localparam int EW  = energy_width(N, W);
    localparam int BW  = NB > 1 ? $clog2(NB) : 1;

    state_t               state, state_n;
    logic [N-1:0]         sig_q, col_q;
    logic [BW-1:0]        beat;
    logic signed [EW-1:0] eprev_q, acc, acc_n, beat_sum, pipe_sum, add_val, energy_q;
    logic                 pipe_v, accept, last, load_e, add_v, improved_q;
    logic signed [DW-1:0] dot [CPB];

    genvar k;
    for (k = 0; k < CPB; k++) begin : g_col
        signed_dot_tree #(
            .VECTOR_SIZE    (N),
            .J_ELEMENT_WIDTH(W),
            .J_SIGNED       (J_SIGNED)
        ) u_tree (
            .sigma(sig_q),
            .j_col(j_data[j_offset(N, W, k, 0) +: N*W]),
            .dot  (dot[k])
        );
    end

    // col_q is shifted down by CPB per beat so its low bits are this beat's column spins
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < CPB; i++)
            beat_sum = beat_sum + (col_q[i] ? EW'(dot[i]) : -EW'(dot[i]));
    end

    always_comb begin
        accept  = state == ST_STREAM && j_valid && !abort;
        last    = accept && beat == BW'(NB - 1);
        add_v   = PIPE_TREE != 0 ? pipe_v : accept;
        add_val = PIPE_TREE != 0 ? pipe_sum : beat_sum;
        acc_n   = add_v ? acc + add_val : acc;
        load_e  = (state == ST_STREAM && last && PIPE_TREE == 0) || (state == ST_DRAIN && !abort);
        j_ready = state == ST_STREAM;
        busy    = state != ST_IDLE;
        done    = state == ST_FINISH;
        state_n = state;
        case (state)
            ST_IDLE:   state_n = start ? ST_STREAM : ST_IDLE;
            ST_STREAM: state_n = abort ? ST_IDLE : !last ? ST_STREAM : PIPE_TREE != 0 ? ST_DRAIN : ST_FINISH;
            ST_DRAIN:  state_n = abort ? ST_IDLE : ST_FINISH;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sig_q      <= '0;
            col_q      <= '0;
            eprev_q    <= '0;
            acc        <= '0;
            beat       <= '0;
            pipe_v     <= 1'b0;
            pipe_sum   <= '0;
            energy_q   <= '0;
            improved_q <= 1'b0;
        end else begin
            state    <= state_n;
            pipe_v   <= accept;
            pipe_sum <= beat_sum;
            if (state == ST_IDLE && start) begin
                sig_q   <= sigma;
                col_q   <= sigma;
                eprev_q <= energy_prev;
                acc     <= '0;
                beat    <= '0;
            end else begin
                acc <= acc_n;
                if (accept) begin
                    beat  <= beat + 1'b1;
                    col_q <= col_q >> CPB;
                end
            end
            if (load_e) begin
                energy_q   <= acc_n;
                improved_q <= acc_n < eprev_q;
            end
        end
    end

    assign energy   = energy_q;
    assign improved = improved_q;

endmodule

// File: tb/tb_ising_energy_stream.sv
// tb_ising_energy_stream: directed tables plus golden-model runs for default, signed and 8-spin configurations
module tb_ising_energy_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, start, abort, j_valid;
    logic [255:0]         sigma;
    logic signed [20:0]   energy_prev;
    logic [4095:0]        j_data;
    logic                 j_ready0, busy0, done0, improved0;
    logic                 j_ready1, busy1, done1, improved1;
    logic signed [20:0]   energy0, energy1;

    logic                 start8, abort8, jv8;
    logic [7:0]           sigma8;
    logic signed [10:0]   ep8;
    logic [255:0]         jd8;
    logic                 ready_a, busy_a, done_a, imp_a;
    logic                 ready_b, busy_b, done_b, imp_b;
    logic signed [10:0]   en_a, en_b;

    ising_energy_stream dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .sigma(sigma), .energy_prev(energy_prev),
        .j_valid(j_valid), .j_ready(j_ready0), .j_data(j_data), .abort(abort),
        .busy(busy0), .done(done0), .energy(energy0), .improved(improved0)
    );

    ising_energy_stream #(.J_SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .sigma(sigma), .energy_prev(energy_prev),
        .j_valid(j_valid), .j_ready(j_ready1), .j_data(j_data), .abort(abort),
        .busy(busy1), .done(done1), .energy(energy1), .improved(improved1)
    );

    ising_energy_stream #(.VECTOR_SIZE(8), .COLS_PER_BEAT(8), .PIPE_TREE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start8), .sigma(sigma8), .energy_prev(ep8),
        .j_valid(jv8), .j_ready(ready_a), .j_data(jd8), .abort(abort8),
        .busy(busy_a), .done(done_a), .energy(en_a), .improved(imp_a)
    );

    ising_energy_stream #(.VECTOR_SIZE(8), .COLS_PER_BEAT(8), .PIPE_TREE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start8), .sigma(sigma8), .energy_prev(ep8),
        .j_valid(jv8), .j_ready(ready_b), .j_data(jd8), .abort(abort8),
        .busy(busy_b), .done(done_b), .energy(en_b), .improved(imp_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int ready_bad = 0;
    logic [3:0] jm [256][256];

    typedef struct {
        logic [255:0] sg;
        logic [3:0]   jv;
        longint       ep;
        longint       eu;
        bit           iu;
        longint       es;
        bit           isg;
    } big_vec_t;

    typedef struct {
        logic [7:0] sg;
        logic [3:0] jv;
        longint     ep;
        bit         ab;
        longint     ee;
        bit         ei;
    } small_vec_t;

    task automatic check(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (j_ready0 && !busy0) ready_bad++;
    endtask

    task automatic fill_uniform(input logic [3:0] v);
        for (int r = 0; r < 256; r++)
            for (int c = 0; c < 256; c++) jm[r][c] = v;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 256; r++)
            for (int c = 0; c < 256; c++) jm[r][c] = 4'($urandom_range(0, 15));
    endtask

    task automatic set_beat(input int b);
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 256; r++) j_data[(k*256+r)*4 +: 4] = jm[r][b*4+k];
    endtask

    function automatic longint gold(input logic [255:0] sg, input bit sgn);
        longint e, row, jv;
        e = 0;
        for (int r = 0; r < 256; r++) begin
            row = 0;
            for (int c = 0; c < 256; c++) begin
                jv = sgn ? longint'($signed(jm[r][c])) : longint'(jm[r][c]);
                row += sg[c] ? jv : -jv;
            end
            e += sg[r] ? row : -row;
        end
        return e;
    endfunction

    task automatic run_big(input string tag, input logic [255:0] sg, input longint ep, input bit gaps,
                           input longint eu, input bit iu, input longint es, input bit isg);
        int nb, cyc;
        bit acc, got;
        sigma = sg;
        energy_prev = ep[20:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_start"}, busy0, 1);
        nb = 0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 1000) begin
            set_beat(nb < 64 ? nb : 0);
            j_valid = !gaps || $urandom_range(0, 3) != 0;
            acc = j_valid && j_ready0;
            tick();
            cyc++;
            if (acc) nb++;
            got = done0;
        end
        j_valid = 1'b0;
        check({tag, "_done_seen"}, got, 1);
        if (!gaps) check({tag, "_latency"}, cyc + 1, 66);
        check({tag, "_beats"}, nb, 64);
        check({tag, "_energy_u"}, energy0, eu);
        check({tag, "_improved_u"}, improved0, iu);
        check({tag, "_done_s"}, done1, 1);
        check({tag, "_energy_s"}, energy1, es);
        check({tag, "_improved_s"}, improved1, isg);
        tick();
        check({tag, "_done_low"}, done0, 0);
        check({tag, "_busy_low"}, busy0, 0);
    endtask

    task automatic run_small(input string tag, input small_vec_t v);
        int ca, cb;
        sigma8 = v.sg;
        ep8 = v.ep[10:0];
        jd8 = {64{v.jv}};
        start8 = 1'b1;
        abort8 = v.ab;
        tick();
        start8 = 1'b0;
        abort8 = 1'b0;
        check({tag, "_busy"}, busy_a, 1);
        jv8 = 1'b1;
        ca = 0;
        cb = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (done_a && ca == 0) ca = c;
            if (done_b && cb == 0) cb = c;
        end
        jv8 = 1'b0;
        check({tag, "_lat_a"}, ca, 1);
        check({tag, "_lat_b"}, cb, 2);
        check({tag, "_energy_a"}, en_a, v.ee);
        check({tag, "_energy_b"}, en_b, v.ee);
        check({tag, "_imp_a"}, imp_a, v.ei);
        check({tag, "_imp_b"}, imp_b, v.ei);
    endtask

    initial begin
        big_vec_t   bt [7];
        small_vec_t st [5];
        logic [255:0] sg;
        longint gu, gs, ep, saved_e;
        bit saved_i, seen;

        bt[0] = '{{256{1'b1}}, 4'd1, 0, 65536, 0, 65536, 0};
        bt[1] = '{{256{1'b0}}, 4'd1, 0, 65536, 0, 65536, 0};
        bt[2] = '{{128{2'b10}}, 4'd1, 0, 0, 0, 0, 0};
        bt[3] = '{{128{2'b10}}, 4'd1, 1, 0, 1, 0, 1};
        bt[4] = '{{256{1'b1}}, 4'd8, 0, 524288, 0, -524288, 1};
        bt[5] = '{{256{1'b1}}, 4'd15, 0, 983040, 0, -65536, 1};
        bt[6] = '{{{64{1'b0}}, {192{1'b1}}}, 4'd2, 40000, 32768, 1, 32768, 1};

        st[0] = '{8'hFF, 4'd0, -1, 0, 0, 0};
        st[1] = '{8'hFF, 4'd1, 0, 0, 64, 0};
        st[2] = '{8'h0F, 4'd7, 5, 1, 0, 1};
        st[3] = '{8'h01, 4'd2, 100, 0, 72, 1};
        st[4] = '{8'h00, 4'd15, 0, 0, 960, 0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; j_valid = 1'b0; sigma = '0; energy_prev = '0; j_data = '0;
        start8 = 1'b0; abort8 = 1'b0; jv8 = 1'b0; sigma8 = '0; ep8 = '0; jd8 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_ready", j_ready0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_energy", energy0, 0);
        check("rst_improved", improved0, 0);
        check("rst_busy_a", busy_a, 0);
        tick();

        for (int i = 0; i < 5; i++) run_small($sformatf("small%0d", i), st[i]);

        // reset while the 8-spin engines sit in STREAM waiting for their beat
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        check("midrst8_ready_pre", ready_b, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst8_busy_a", busy_a, 0);
        check("midrst8_ready_b", ready_b, 0);
        check("midrst8_done_b", done_b, 0);
        check("midrst8_energy_a", en_a, 0);
        check("midrst8_energy_b", en_b, 0);
        tick();
        run_small("small_after_rst", st[3]);

        for (int i = 0; i < 7; i++) begin
            fill_uniform(bt[i].jv);
            run_big($sformatf("big%0d", i), bt[i].sg, bt[i].ep, 1'b0, bt[i].eu, bt[i].iu, bt[i].es, bt[i].isg);
        end

        for (int s = 0; s < 6; s++) begin
            fill_random();
            for (int i = 0; i < 8; i++) sg[i*32 +: 32] = $urandom();
            gu = gold(sg, 1'b0);
            gs = gold(sg, 1'b1);
            ep = gu + longint'($urandom_range(0, 2000)) - 1000;
            run_big($sformatf("rand%0d", s), sg, ep, 1'b1, gu, gu < ep, gs, gs < ep);
        end

        // abort after ten beats: no result, previous energy kept, next run clean
        saved_e = energy0;
        saved_i = improved0;
        fill_random();
        for (int i = 0; i < 8; i++) sg[i*32 +: 32] = $urandom();
        sigma = sg;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 10; b++) begin
            set_beat(b);
            j_valid = 1'b1;
            tick();
        end
        set_beat(10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        j_valid = 1'b0;
        check("abort_busy", busy0, 0);
        check("abort_ready", j_ready0, 0);
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (done0 || done1) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        check("abort_energy_kept", energy0, saved_e);
        check("abort_improved_kept", improved0, saved_i);
        gu = gold(sg, 1'b0);
        gs = gold(sg, 1'b1);
        run_big("after_abort", sg, 0, 1'b0, gu, gu < 0, gs, gs < 0);

        // reset mid-stream on the default engine
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            set_beat(b);
            j_valid = 1'b1;
            tick();
        end
        j_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", busy0, 0);
        check("midrst_ready", j_ready0, 0);
        check("midrst_energy", energy0, 0);
        check("midrst_improved", improved0, 0);
        check("midrst_energy_s", energy1, 0);
        tick();
        run_big("after_rst", sg, 0, 1'b1, gu, gu < 0, gs, gs < 0);

        check("ready_outside_stream", ready_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
